// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter feeding the 8-to-3 encoder.
// Issues a registered one-hot grant that is held until ack, then rotates
// priority so the requester just served becomes lowest priority.
// Optional feature: define RR_TIMEOUT_EN to force-release a grant held for
// TIMEOUT_CYCLES cycles without ack (pulses timeout for one cycle).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no grant outstanding; pick next winner from r_ptr upward
// S_GRANT| one-hot grant locked until ack (or forced release)
module rr_req_arbiter #(
  parameter int N_REQ          = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [N_REQ-1:0] gnt,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2) begin : g_bad_n_req
    $error("rr_req_arbiter: N_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("rr_req_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_win, w_win_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic             r_gnt_valid, w_gnt_valid_nxt;

  logic             w_found;
  logic [PW-1:0]    w_pick;
  logic [PW:0]      w_idx;
  logic [PW:0]      w_inc;
  logic [PW-1:0]    w_ptr_inc;
  logic             w_release;

`ifdef RR_TIMEOUT_EN
  logic [7:0]       r_hold, w_hold_nxt;
  logic             r_timeout, w_timeout_nxt;
`endif

  // Find the first active request scanning upward from r_ptr with wrap.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= (PW+1)'(N_REQ)) w_idx = w_idx - (PW+1)'(N_REQ);
      if (!w_found && req[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[PW-1:0];
      end
    end
  end

  // Pointer value after releasing the current winner: one past it, wrapping.
  always_comb begin
    w_inc     = {1'b0, r_win} + (PW+1)'(1);
    w_ptr_inc = (w_inc == (PW+1)'(N_REQ)) ? '0 : w_inc[PW-1:0];
  end

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_win_nxt       = r_win;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    w_release       = 1'b0;
`ifdef RR_TIMEOUT_EN
    w_hold_nxt      = r_hold;
    w_timeout_nxt   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
        if (w_found) begin
          w_gnt_nxt[w_pick] = 1'b1;
          w_gnt_valid_nxt   = 1'b1;
          w_win_nxt         = w_pick;
          w_state_nxt       = S_GRANT;
        end
`ifdef RR_TIMEOUT_EN
        w_hold_nxt = '0;
`endif
      end
      S_GRANT: begin
        // ack wins over a timeout landing on the same cycle
        if (ack) begin
          w_release = 1'b1;
`ifdef RR_TIMEOUT_EN
        end else if (r_hold == 8'(TIMEOUT_CYCLES - 1)) begin
          w_release     = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_hold_nxt = r_hold + 8'd1;
`endif
        end
        if (w_release) begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = w_ptr_inc;
          w_state_nxt     = S_IDLE;
`ifdef RR_TIMEOUT_EN
          w_hold_nxt      = '0;
`endif
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
`ifdef RR_TIMEOUT_EN
      r_hold      <= '0;
      r_timeout   <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_win       <= w_win_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
`ifdef RR_TIMEOUT_EN
      r_hold      <= w_hold_nxt;
      r_timeout   <= w_timeout_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
`ifdef RR_TIMEOUT_EN
  assign timeout   = r_timeout;
`else
  assign timeout   = 1'b0;
`endif

endmodule
